// File: rtl/output_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : output_unit_if
//  Description : Result/display bundle between the result source and the
//                output_unit seven-segment driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface output_unit_if;
  logic        load;       // start request
  logic [7:0]  A;          // two's-complement result
  logic        err;        // result-invalid flag
  logic        busy;       // conversion in progress
  logic        done;       // one-cycle pulse when new results are latched
  logic [11:0] bcd;        // {hundreds, tens, ones}
  logic        neg;        // latched sign
  logic [3:0]  digit_sel;  // one-hot digit enable, bit 0 = ones
  logic [6:0]  seg;        // {g,f,e,d,c,b,a}

  // Result source side
  modport master (
    output load, A, err,
    input  busy, done, bcd, neg, digit_sel, seg
  );

  // Display driver side
  modport slave (
    input  load, A, err,
    output busy, done, bcd, neg, digit_sel, seg
  );
endinterface
`default_nettype wire

// File: rtl/output_unit.sv
`default_nettype none
// ============================================================================
//  Module      : output_unit
//  Description : Signed 8-bit result to BCD (double-dabble) conversion and
//                four-digit multiplexed seven-segment display driver.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_unit #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic         clock,
  input  logic         Reset,
  output_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ABS   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int            CW         = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]    SEG_DASH   = 7'b1000000;
  localparam logic [6:0]    SEG_BLANK  = 7'b0000000;
  localparam logic [6:0]    SEG_ZERO   = 7'b0111111;
  localparam logic [6:0]    SEG_RESET  = SEG_ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;

  // Active-high segment pattern for one BCD digit
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b0111111;
      4'd1:    seg_digit = 7'b0000110;
      4'd2:    seg_digit = 7'b1011011;
      4'd3:    seg_digit = 7'b1001111;
      4'd4:    seg_digit = 7'b1100110;
      4'd5:    seg_digit = 7'b1101101;
      4'd6:    seg_digit = 7'b1111101;
      4'd7:    seg_digit = 7'b0000111;
      4'd8:    seg_digit = 7'b1111111;
      4'd9:    seg_digit = 7'b1101111;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic          err_in_q, err_in_d;
  logic [7:0]    mag_q, mag_d;
  logic [11:0]   scratch_q, scratch_d;
  logic [2:0]    iter_q, iter_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          neg_q, neg_d;
  logic          errf_q, errf_d;
  logic [CW-1:0] scan_q, scan_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [6:0]    seg_q, seg_d;
  logic [11:0]   adj;
  logic [6:0]    raw;

  // Conversion FSM: capture, absolute value, eight shift-add-3 steps, latch
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    err_in_d  = err_in_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    errf_d    = errf_q;
    adj       = scratch_q;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          a_d      = bus.A;
          err_in_d = bus.err;
          state_d  = ABS;
        end
      end
      ABS: begin
        // 8'h80 negates to 8'h80, which reads as 128 unsigned
        mag_d     = a_q[7] ? (~a_q + 8'd1) : a_q;
        scratch_d = 12'd0;
        iter_d    = 3'd0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        for (int i = 0; i < 3; i++) begin
          if (scratch_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
          end
        end
        {scratch_d, mag_d} = {adj, mag_q} << 1;
        if (iter_q == 3'd7) begin
          state_d = DONE;
        end else begin
          iter_d = iter_q + 3'd1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        bcd_d   = scratch_q;
        neg_d   = a_q[7];
        errf_d  = err_in_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // busy also covers the cycle in which done is presented
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  // Display scan and segment encoding; uses next-cycle values so seg,
  // digit_sel and the latched result always agree
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + CW'(1);
    idx_d  = (scan_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    sel_d  = 4'b0001 << idx_d;
    raw    = SEG_BLANK;
    case (idx_d)
      2'd0: raw = seg_digit(bcd_d[3:0]);
      2'd1: raw = (bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0) ? SEG_BLANK
                                                                : seg_digit(bcd_d[7:4]);
      2'd2: raw = (bcd_d[11:8] == 4'd0) ? SEG_BLANK : seg_digit(bcd_d[11:8]);
      2'd3: raw = neg_d ? SEG_DASH : SEG_BLANK;
      default: raw = SEG_BLANK;
    endcase
    if (errf_d) begin
      raw = SEG_DASH;
    end
    seg_d = SEG_ACTIVE_LOW ? ~raw : raw;
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      a_q       <= 8'd0;
      err_in_q  <= 1'b0;
      mag_q     <= 8'd0;
      scratch_q <= 12'd0;
      iter_q    <= 3'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= 12'd0;
      neg_q     <= 1'b0;
      errf_q    <= 1'b0;
      scan_q    <= '0;
      idx_q     <= 2'd0;
      sel_q     <= 4'b0001;
      seg_q     <= SEG_RESET;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      err_in_q  <= err_in_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      iter_q    <= iter_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      errf_q    <= errf_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.bcd       = bcd_q;
  assign bus.neg       = neg_q;
  assign bus.digit_sel = sel_q;
  assign bus.seg       = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_output_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_unit
//  Description : Directed self-checking bench for output_unit
//                (REFRESH_DIV=4, active-low segments).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_unit;

  logic clock = 1'b0;
  logic Reset = 1'b0;
  int   vecs  = 0;
  int   fails = 0;

  output_unit_if bus ();

  output_unit #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Active-low display patterns
  localparam logic [6:0] L_DASH  = 7'b0111111;
  localparam logic [6:0] L_BLANK = 7'b1111111;
  localparam logic [6:0] L_0     = 7'b1000000;
  localparam logic [6:0] L_1     = 7'b1111001;
  localparam logic [6:0] L_2     = 7'b0100100;
  localparam logic [6:0] L_7     = 7'b1111000;
  localparam logic [6:0] L_8     = 7'b0000000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge
  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Wait (bounded) for a digit to be selected, then check its segments
  task automatic check_digit(input string tag, input logic [3:0] sel, input logic [6:0] exp);
    bit found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.digit_sel === sel) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_sel_seen"}, {15'd0, found}, 16'd1);
    chk(tag, {9'd0, bus.seg}, {9'd0, exp});
  endtask

  // One load pulse with full latency checks; entered 1 unit after an edge
  task automatic run_conv(input string tag, input logic [7:0] a, input logic e,
                          input logic [11:0] exp_bcd, input logic exp_neg);
    bus.load = 1'b1;
    bus.A    = a;
    bus.err  = e;
    sync();                       // edge t
    bus.load = 1'b0;
    chk({tag, "_busy_t"}, {15'd0, bus.busy}, 16'd1);
    repeat (9) @(posedge clock);  // edge t+9
    #1;
    chk({tag, "_done_early"}, {15'd0, bus.done}, 16'd0);
    sync();                       // edge t+10
    chk({tag, "_done"}, {15'd0, bus.done}, 16'd1);
    chk({tag, "_bcd"}, {4'd0, bus.bcd}, {4'd0, exp_bcd});
    chk({tag, "_neg"}, {15'd0, bus.neg}, {15'd0, exp_neg});
    chk({tag, "_busy_t10"}, {15'd0, bus.busy}, 16'd1);
    sync();                       // edge t+11
    chk({tag, "_done_clr"}, {15'd0, bus.done}, 16'd0);
    chk({tag, "_busy_t11"}, {15'd0, bus.busy}, 16'd0);
  endtask

  initial begin
    int ndone;
    bus.load = 1'b0;
    bus.A    = 8'h00;
    bus.err  = 1'b0;

    // Reset state and scan rotation
    repeat (2) @(posedge clock);
    @(negedge clock);
    Reset = 1'b1;
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_done", {15'd0, bus.done}, 16'd0);
    chk("rst_bcd", {4'd0, bus.bcd}, 16'd0);
    chk("rst_neg", {15'd0, bus.neg}, 16'd0);
    chk("rst_sel", {12'd0, bus.digit_sel}, 16'h0001);
    chk("rst_seg", {9'd0, bus.seg}, {9'd0, L_0});
    repeat (3) @(posedge clock);
    #1;
    chk("scan_hold", {12'd0, bus.digit_sel}, 16'h0001);
    sync();
    chk("scan_adv", {12'd0, bus.digit_sel}, 16'h0002);
    check_digit("rst_tens", 4'b0010, L_BLANK);
    check_digit("rst_hund", 4'b0100, L_BLANK);
    check_digit("rst_sign", 4'b1000, L_BLANK);
    check_digit("rst_ones", 4'b0001, L_0);

    // +127
    sync();
    run_conv("p127", 8'h7F, 1'b0, 12'h127, 1'b0);
    check_digit("p127_ones", 4'b0001, L_7);
    check_digit("p127_tens", 4'b0010, L_2);
    check_digit("p127_hund", 4'b0100, L_1);
    check_digit("p127_sign", 4'b1000, L_BLANK);

    // -128
    sync();
    run_conv("m128", 8'h80, 1'b0, 12'h128, 1'b1);
    check_digit("m128_sign", 4'b1000, L_DASH);
    check_digit("m128_ones", 4'b0001, L_8);
    check_digit("m128_tens", 4'b0010, L_2);
    check_digit("m128_hund", 4'b0100, L_1);

    // -10
    sync();
    run_conv("m10", 8'hF6, 1'b0, 12'h010, 1'b1);
    check_digit("m10_ones", 4'b0001, L_0);
    check_digit("m10_tens", 4'b0010, L_1);
    check_digit("m10_hund", 4'b0100, L_BLANK);
    check_digit("m10_sign", 4'b1000, L_DASH);

    // 5 with error flag
    sync();
    run_conv("err5", 8'h05, 1'b1, 12'h005, 1'b0);
    check_digit("err5_ones", 4'b0001, L_DASH);
    check_digit("err5_tens", 4'b0010, L_DASH);
    check_digit("err5_hund", 4'b0100, L_DASH);
    check_digit("err5_sign", 4'b1000, L_DASH);

    // Second load during a conversion is ignored
    sync();
    bus.load = 1'b1;
    bus.A    = 8'h01;
    bus.err  = 1'b0;
    ndone    = 0;
    sync();
    bus.load = 1'b0;
    repeat (2) sync();
    bus.load = 1'b1;
    bus.A    = 8'h02;
    sync();
    bus.load = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.done === 1'b1) ndone++;
      sync();
    end
    chk("ovl_ndone", 16'(ndone), 16'd1);
    chk("ovl_bcd", {4'd0, bus.bcd}, 16'h0001);
    check_digit("ovl_ones", 4'b0001, L_1);

    // Load held high restarts right after DONE
    sync();
    bus.load = 1'b1;
    bus.A    = 8'h2A;
    sync();                       // edge t
    repeat (10) @(posedge clock); // edge t+10
    #1;
    chk("hold_done1", {15'd0, bus.done}, 16'd1);
    chk("hold_bcd", {4'd0, bus.bcd}, 16'h0042);
    sync();                       // edge t+11: second capture
    chk("hold_busy", {15'd0, bus.busy}, 16'd1);
    repeat (10) @(posedge clock); // edge t+21
    #1;
    bus.load = 1'b0;
    chk("hold_done2", {15'd0, bus.done}, 16'd1);
    repeat (3) sync();

    // Reset in SHIFT after a result of 127
    run_conv("pre_rst", 8'h7F, 1'b0, 12'h127, 1'b0);
    bus.load = 1'b1;
    bus.A    = 8'h05;
    sync();
    bus.load = 1'b0;
    repeat (3) sync();
    Reset = 1'b0;
    sync();
    Reset = 1'b1;
    chk("abort_busy", {15'd0, bus.busy}, 16'd0);
    chk("abort_bcd", {4'd0, bus.bcd}, 16'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) ndone++;
      sync();
    end
    chk("abort_ndone", 16'(ndone), 16'd0);
    chk("abort_neg", {15'd0, bus.neg}, 16'd0);
    check_digit("abort_ones", 4'b0001, L_0);
    check_digit("abort_tens", 4'b0010, L_BLANK);
    check_digit("abort_hund", 4'b0100, L_BLANK);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_unit.md
# output_unit

Result-side display driver for the eight-bit signed calculator. It accepts an 8-bit two's-complement result plus an error flag, converts the magnitude to three BCD digits with an iterative shift-add-3 (double-dabble) engine, and drives a time-multiplexed four-digit seven-segment display. The digit order is sign, hundreds, tens, ones. It is the output counterpart of the keypad/BCD input path and sits after the ALU.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays selected. Must be ≥ 2.
- SEG_ACTIVE_LOW, 1: when 1, `seg` is inverted at the output.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- load  in  1  start request; sampled only in IDLE.
- A  in  8  result in two's complement, range -128..127.
- err  in  1  result-invalid flag (overflow or out-of-range entry); sampled with `load`.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when new results are latched.
- bcd  out  12  latched magnitude as {hundreds, tens, ones}.
- neg  out  1  latched sign; 1 means the result is negative.
- digit_sel  out  4  one-hot digit enable, active-high. Bit 0 is ones, bit 3 is sign.
- seg  out  7  segment bus {g,f,e,d,c,b,a}; polarity is set by SEG_ACTIVE_LOW.

## Operation
- FSM states: IDLE → ABS → SHIFT → DONE → IDLE.
- IDLE:
  - On `load`=1, capture `A` and `err`, then go to ABS.
  - `load` in any other state is ignored. There is no queueing.
- ABS (1 cycle):
  - mag = A[7] ? (~A + 1) : A, computed in 8 bits.
  - A = 8'h80 gives mag = 128. This is correct as unsigned.
  - Clear the 12-bit BCD scratch register and the iteration counter.
- SHIFT (exactly 8 cycles):
  - Each cycle, add 3 to every BCD nibble that is ≥ 5.
  - Then shift {scratch, mag} left by one.
  - The counter runs 0..7; leave the state when the count reaches 7.
- DONE (1 cycle):
  - `done` = 1.
  - Latch `bcd` ← scratch, `neg` ← captured A[7], and the display error flag ← captured `err`.
  - Return to IDLE.
- The display registers change only in DONE. The previous value stays on the display during a conversion.
- A conversion runs even when `err` is 1. `bcd` and `neg` are still updated.
- Display scan:
  - A free-running counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0→1→2→3→0.
  - `digit_sel` = 1 << index.
- Digit content, with the error flag clear:
  - ones: always shown.
  - tens: blank if hundreds = 0 and tens = 0.
  - hundreds: blank if 0.
  - sign: '-' if `neg`, otherwise blank.
- Digit content, with the error flag set: all four digits show '-'.
- Active-high encodings:
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0000111, 8 = 1111111, 9 = 1101111
  - '-' = 1000000, blank = 0000000
- `seg` is registered. It updates in the same cycle as `digit_sel`.

## Timing
- Reset (Reset=0 at a rising edge):
  - FSM goes to IDLE. `busy`=0, `done`=0, `bcd`=0, `neg`=0, error flag = 0.
  - Scan counter = 0, index = 0, `digit_sel`=0001.
  - `seg` shows '0' (1000000 when SEG_ACTIVE_LOW=1).
  - The display reads "   0".
- Reset during a conversion aborts it. No `done` is produced, and the display returns to "   0".
- Latency: `load` is sampled at edge t.
  - `busy` is 1 from edge t through edge t+10.
  - `done`, `bcd` and `neg` become valid after edge t+10.
  - `busy` is back to 0 after edge t+11.
- Throughput: at most one conversion per 11 cycles.
- `load` held high continuously restarts a conversion on the first IDLE cycle after DONE.
- The scan counter is independent of the FSM. A DONE edge does not reset the scan.

## Test plan
- Reset with SEG_ACTIVE_LOW=1, REFRESH_DIV=4 → `digit_sel` rotates 0001→0010→0100→1000 every 4 cycles. `seg`=1000000 on ones and 1111111 on the other three digits.
- A=8'h7F, load pulse → `done` exactly 10 cycles after the load edge; `bcd`=12'h127, `neg`=0; display " 127".
- A=8'h80 → `bcd`=12'h128, `neg`=1; display "-128". A=8'hF6 → `bcd`=12'h010, `neg`=1; display "- 10".
- A=8'h05 with err=1 → `bcd`=12'h005; all four digits show '-' (0111111 active-low).
- Second `load` 3 cycles into a conversion (A=8'h01 then A=8'h02) → exactly one `done`, with `bcd`=12'h001.
- Reset asserted in SHIFT after a prior result of 127 → no `done`; `bcd`=0, display "   0", `busy`=0 on the next cycle.
